// File: rtl/cpu_common_pkg.sv
// Shared CPU type package.
// Holds the op-type enums used by the execute-stage units (ALU, multiplier,
// divider) plus small helpers shared between them.
package cpu_common;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU
  } mul_op_t;

  typedef enum logic [1:0] {
    DIV,
    DIVU,
    REM,
    REMU
  } div_op_t;

  // Sign-extend a 32-bit word to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative integer divider for DIV/DIVU/REM/REMU and their W variants.
// Radix-2 restoring shift-subtract on operand magnitudes, one quotient bit
// per cycle; signs are applied when the last bit is produced.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_valid / o_ready        request handshake from EX
//   i_op, i_is_32            operation and W-variant select
//   i_operand_a/b            dividend / divisor
//   i_flush                  kill any in-flight operation
//   o_valid / i_ready        result handshake to downstream
//   o_value                  quotient or remainder
module div_unit
  import cpu_common::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  div_op_t         i_op,
  input  logic            i_is_32,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_value
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operation context
  logic [5:0]      count;
  div_op_t         op_q;
  logic            is_32_q;
  logic            quot_neg_q;
  logic            rem_neg_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;

  // Request decode
  logic            accept;
  logic            in_signed;
  logic            in_rem;
  logic [XLEN-1:0] a_eff;
  logic [XLEN-1:0] b_eff;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic [XLEN-1:0] dbz_value;

  // Iteration step
  logic            step_en;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            qbit;
  logic [XLEN-1:0] quot_step;
  logic [XLEN-1:0] rem_step;

  // Result formation
  logic            is_rem_q;
  logic [XLEN-1:0] quot_res;
  logic [XLEN-1:0] rem_res;
  logic [XLEN-1:0] raw_res;
  logic [XLEN-1:0] final_res;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign accept    = i_valid && (state == IDLE) && !i_flush;
  assign in_signed = (i_op == DIV) || (i_op == REM);
  assign in_rem    = (i_op == REM) || (i_op == REMU);

  always_comb begin
    a_eff = i_operand_a;
    b_eff = i_operand_b;
    if (i_is_32) begin
      if (in_signed) begin
        a_eff = sext32(i_operand_a[31:0]);
        b_eff = sext32(i_operand_b[31:0]);
      end else begin
        a_eff = {32'b0, i_operand_a[31:0]};
        b_eff = {32'b0, i_operand_b[31:0]};
      end
    end
  end

  assign sign_a = in_signed && a_eff[XLEN-1];
  assign sign_b = in_signed && b_eff[XLEN-1];
  assign mag_a  = sign_a ? (~a_eff + 64'd1) : a_eff;
  assign mag_b  = sign_b ? (~b_eff + 64'd1) : b_eff;
  assign b_zero = (b_eff == '0);

  // Divide-by-zero: quotient is all ones, remainder is the dividend; the
  // W form of the dividend is re-extended from bit 31 even for REMUW.
  always_comb begin
    dbz_value = '1;
    if (in_rem) begin
      dbz_value = i_is_32 ? sext32(i_operand_a[31:0]) : i_operand_a;
    end
  end

  // ---------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the difference when it does not go negative.
  // The dividend bits are consumed from bit 63 of quot_q; W operands are
  // loaded into the upper half so the same tap serves both widths.
  // ---------------------------------------------------------------------
  assign step_en   = (state == BUSY) && !i_flush;
  assign shifted   = {rem_q, quot_q[XLEN-1]};
  assign diff      = shifted - {1'b0, divisor_q};
  assign qbit      = ~diff[XLEN];
  assign rem_step  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], qbit};

  // ---------------------------------------------------------------------
  // Sign application. MIN / -1 needs no special case: the magnitude
  // quotient is 2^(N-1), which negates back onto itself.
  // ---------------------------------------------------------------------
  assign is_rem_q = (op_q == REM) || (op_q == REMU);
  assign quot_res = quot_neg_q ? (~quot_step + 64'd1) : quot_step;
  assign rem_res  = rem_neg_q ? (~rem_step + 64'd1) : rem_step;
  assign raw_res  = is_rem_q ? rem_res : quot_res;

  always_comb begin
    final_res = raw_res;
    if (is_32_q) begin
      final_res = sext32(raw_res[31:0]);
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (accept) begin
          state_next = b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Flush overrides acceptance, completion and hand-off alike.
    if (i_flush) begin
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      op_q       <= DIV;
      is_32_q    <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      o_value    <= '0;
    end else if (accept) begin
      op_q       <= i_op;
      is_32_q    <= i_is_32;
      quot_neg_q <= sign_a ^ sign_b;
      rem_neg_q  <= sign_a;
      divisor_q  <= mag_b;
      quot_q     <= i_is_32 ? {mag_a[31:0], 32'b0} : mag_a;
      rem_q      <= '0;
      count      <= i_is_32 ? 6'd31 : 6'd63;
      if (b_zero) begin
        o_value <= dbz_value;
      end
    end else if (step_en) begin
      quot_q <= quot_step;
      rem_q  <= rem_step;
      count  <= count - 6'd1;
      if (count == '0) begin
        o_value <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases with literal
// results and latencies, then randomized traffic with random back-pressure,
// flushes and stray requests, all checked every cycle against a
// timestamp-based reference model.
module tb_div_unit;
  import cpu_common::*;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  div_op_t     i_op;
  logic        i_is_32;
  logic [63:0] i_operand_a;
  logic [63:0] i_operand_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_value;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_is_32    (i_is_32),
    .i_operand_a(i_operand_a),
    .i_operand_b(i_operand_b),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_value    (o_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_result(input div_op_t op, input bit is32,
                                             input logic [63:0] a, input logic [63:0] b);
    bit          is_rem;
    bit          sgn;
    logic [31:0] a32, b32, q32, r32, res32;
    logic [63:0] q64, r64;
    int          sa32, sb32;
    longint      sa64, sb64;
    is_rem = (op == REM) || (op == REMU);
    sgn    = (op == DIV) || (op == REM);
    if (is32) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1;
        r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = 0;
      end else if (sgn) begin
        sa32 = a32;
        sb32 = b32;
        q32  = sa32 / sb32;
        r32  = sa32 % sb32;
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      res32 = is_rem ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 0) begin
      q64 = '1;
      r64 = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q64 = a;
      r64 = 0;
    end else if (sgn) begin
      sa64 = a;
      sb64 = b;
      q64  = sa64 / sb64;
      r64  = sa64 % sb64;
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return is_rem ? r64 : q64;
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: an op is in flight from its accepting edge until the
  // edge where its result is handed off or it is flushed/reset. The result
  // becomes visible N cycles after the first cycle in flight (immediately
  // on divide-by-zero).
  // ---------------------------------------------------------------------
  bit          m_active = 1'b0;
  longint      cyc = 0;
  longint      m_valid_from = 0;
  logic [63:0] m_value = '0;
  bit          m_pre_valid;
  bit          m_bzero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
    end else begin
      m_pre_valid = m_active && (cyc >= m_valid_from);
      cyc++;
      if (i_flush) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_pre_valid && i_ready) m_active = 1'b0;
      end else if (i_valid) begin
        m_active     = 1'b1;
        m_value      = ref_result(i_op, i_is_32, i_operand_a, i_operand_b);
        m_bzero      = i_is_32 ? (i_operand_b[31:0] == 0) : (i_operand_b == 0);
        m_valid_from = cyc + (m_bzero ? 0 : (i_is_32 ? 32 : 64));
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = m_active && (cyc >= m_valid_from);
    check("cyc_o_ready", 64'(o_ready), 64'(!m_active));
    check("cyc_o_valid", 64'(o_valid), 64'(exp_valid));
    if (exp_valid) check("cyc_o_value", o_value, m_value);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Directed op with literal expected value and latency; optionally holds
  // i_ready low for 'hold' cycles once the result appears.
  task automatic do_op(input string name, input div_op_t op, input bit is32,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input int hold);
    int n;
    int lat;
    n = 0;
    while (!o_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({name, "_ready_timeout"}, 64'(o_ready), 64'd1);
    i_op        = op;
    i_is_32     = is32;
    i_operand_a = a;
    i_operand_b = b;
    i_valid     = 1'b1;
    i_ready     = (hold == 0);
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_val"}, o_value, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_hold_val"}, o_value, exp);
      check({name, "_hold_valid"}, 64'(o_valid), 64'd1);
      check({name, "_hold_ready"}, 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    tick();
    check({name, "_ready_after"}, 64'(o_ready), 64'd1);
    check({name, "_valid_after"}, 64'(o_valid), 64'd0);
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h0000_0000_8000_0000;
      4: v = 64'($urandom_range(1, 20));
      5: v = {32'h0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    if ($urandom_range(0, 5) == 0) v = ~v + 64'd1;
    return v;
  endfunction

  task automatic rand_op();
    int flush_at;
    int c;
    i_op        = div_op_t'($urandom_range(0, 3));
    i_is_32     = $urandom_range(0, 2) == 0;
    i_operand_a = rand_operand();
    i_operand_b = rand_operand();
    i_valid     = 1'b1;
    i_ready     = $urandom_range(0, 2) != 0;
    tick();
    i_valid  = 1'b0;
    flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 70) : 0;
    c = 1;
    while (m_active && c < 200) begin
      i_ready = $urandom_range(0, 2) != 0;
      i_valid = $urandom_range(0, 4) == 0;
      if (i_valid) begin
        i_op        = div_op_t'($urandom_range(0, 3));
        i_operand_a = rand_operand();
        i_operand_b = rand_operand();
      end
      i_flush = (c == flush_at);
      tick();
      c++;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    if (c >= 200) check("rand_op_timeout", 64'(m_active), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_op        = DIV;
    i_is_32     = 1'b0;
    i_operand_a = '0;
    i_operand_b = '0;
    i_flush     = 1'b0;
    i_ready     = 1'b1;

    // Pin the reference model to hand-computed results.
    check("ref_div_neg7_2",  ref_result(DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("ref_rem_neg7_2",  ref_result(REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check("ref_divu_by0",    ref_result(DIVU, 0, 64'd12345, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("ref_remuw_by0",   ref_result(REMU, 1, 64'h1_8000_0000, 64'd0), 64'hFFFF_FFFF_8000_0000);
    check("ref_div_ovf",     ref_result(DIV, 0, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);
    check("ref_rem_ovf",     ref_result(REM, 0, 64'h8000_0000_0000_0000, '1), 64'd0);
    check("ref_divw_ovf",    ref_result(DIV, 1, 64'h8000_0000, '1), 64'hFFFF_FFFF_8000_0000);
    check("ref_divuw_ones",  ref_result(DIVU, 1, 64'hFFFF_FFFF, 64'd1), 64'hFFFF_FFFF_FFFF_FFFF);
    check("ref_divu_100_7",  ref_result(DIVU, 0, 64'd100, 64'd7), 64'd14);

    // Reset state
    tick();
    check("rst_o_ready", 64'(o_ready), 64'd1);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_value", o_value, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed corner cases
    do_op("div_neg7",  DIV,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5);
    do_op("rem_neg7",  REM,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("divu_by0",  DIVU, 0, 64'hDEAD_BEEF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("remuw_by0", REMU, 1, 64'h1_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("div_ovf",   DIV,  0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65, 0);
    do_op("rem_ovf",   REM,  0, 64'h8000_0000_0000_0000, '1, 64'd0, 65, 0);
    do_op("divw_ovf",  DIV,  1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 33, 0);
    do_op("divuw_one", DIVU, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 2);

    // Flush in BUSY cycle 10 together with a new request
    i_op        = DIV;
    i_is_32     = 1'b0;
    i_operand_a = 64'd1000;
    i_operand_b = 64'd3;
    i_valid     = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    i_flush     = 1'b1;
    i_valid     = 1'b1;
    i_op        = DIVU;
    i_operand_a = 64'd55;
    i_operand_b = 64'd5;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_o_ready", 64'(o_ready), 64'd1);
    check("flush_o_valid", 64'(o_valid), 64'd0);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (o_valid) check("flush_no_valid", 64'(o_valid), 64'd0);
    end
    do_op("divu_100_7", DIVU, 0, 64'd100, 64'd7, 64'd14, 65, 0);

    // Reset in the middle of an operation
    i_op        = DIV;
    i_operand_a = 64'd999;
    i_operand_b = 64'd4;
    i_valid     = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_o_ready", 64'(o_ready), 64'd1);
    check("midrst_o_valid", 64'(o_valid), 64'd0);
    check("midrst_o_value", o_value, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("postrst_o_ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (o_valid) check("postrst_no_valid", 64'(o_valid), 64'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      rand_op();
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port i_valid, input, 1 bit: request valid from the EX stage for DIV-type ops.
REQ-004 SHALL have port o_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port i_op, input, div_op_t: operation DIV, DIVU, REM or REMU.
REQ-006 SHALL have port i_is_32, input, 1 bit: W variant (DIVW/DIVUW/REMW/REMUW).
REQ-007 SHALL have port i_operand_a, input, 64 bits: dividend (EX o_val).
REQ-008 SHALL have port i_operand_b, input, 64 bits: divisor (EX o_val2).
REQ-009 SHALL have port i_flush, input, 1 bit: kill any in-flight operation.
REQ-010 SHALL have port o_valid, output, 1 bit: result valid.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts result.
REQ-012 SHALL have port o_value, output, 64 bits: quotient or remainder.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-014 SHALL accept on i_valid && o_ready; the accepting edge latches op, is_32 and operand magnitudes.
REQ-015 SHALL go IDLE->BUSY on acceptance, or IDLE->DONE when the effective divisor is zero.
REQ-016 SHALL perform radix-2 restoring shift-subtract on unsigned magnitudes, one quotient bit per cycle, using a down-counter of N-1..0 (N=64, or 32 when is_32).
REQ-017 SHALL go BUSY->DONE on the cycle the counter reaches 0, giving o_valid high in cycle k+N+1 for acceptance at cycle k; divide-by-zero gives o_valid in cycle k+1.
REQ-018 SHALL go DONE->IDLE when i_ready is high; while i_ready is low, o_value and o_valid SHALL stay stable.
REQ-019 SHALL take W-variant operands from bits [31:0]: sign-extended for DIV/REM, zero-extended for DIVU/REMU.
REQ-020 SHALL sign-extend every W-variant result from bit 31, including DIVUW/REMUW.
REQ-021 SHALL negate the signed quotient iff operand signs differ and divisor != 0; the signed remainder SHALL take the dividend's sign.
REQ-022 SHALL return quotient = all ones and remainder = dividend (width-adjusted) on divide-by-zero.
REQ-023 SHALL return quotient = dividend and remainder = 0 on signed overflow (MIN / -1, 64- or 32-bit MIN); the magnitude datapath SHALL produce this without a special path.
REQ-024 SHALL go to IDLE on the next edge from any state when i_flush is high, dropping o_valid; flush SHALL win over a simultaneous i_valid (no accept) and over a simultaneous i_ready.
REQ-025 SHALL NOT accept a new request in the same cycle that DONE is being left; back-to-back throughput is one op per N+2 cycles.

Reset
REQ-026 SHALL set state=IDLE, counter=0, o_valid=0, o_value=0 and all datapath registers to 0 on rst, asynchronously.
REQ-027 SHALL abandon any op when rst asserts mid-operation, produce no o_valid for it, and have o_ready high in the first cycle after deassertion.

Structure
REQ-028 SHALL take div_op_t (DIV, DIVU, REM, REMU) from the shared cpu_common package, alongside the existing op-type enums.
REQ-029 SHALL be a single module with no sub-module; the step logic is one 65-bit subtract plus shift.

Verification
REQ-030 SHALL cover DIV, a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> o_value=0xFFFF_FFFF_FFFF_FFFD, o_valid exactly 65 cycles after accept; REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-031 SHALL cover DIVU, b=0 -> 0xFFFF_FFFF_FFFF_FFFF one cycle after accept; REMUW, a=0x1_8000_0000, b=0 -> 0xFFFF_FFFF_8000_0000.
REQ-032 SHALL cover DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM -> 0; DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
REQ-033 SHALL cover DIVUW, a=0xFFFF_FFFF, b=1 -> 0xFFFF_FFFF_FFFF_FFFF, o_valid 33 cycles after accept.
REQ-034 SHALL cover i_ready held low 5 cycles in DONE -> o_value constant and o_ready low throughout, then o_ready high one cycle after i_ready rises.
REQ-035 SHALL cover i_flush at BUSY cycle 10 together with i_valid high -> IDLE next cycle, no o_valid, no accept; a fresh DIVU 100/7 then returns 14.
